// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and helpers for the serial receive path
package serial_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

    // Bit counter must be able to hold the value NBITS.
    function automatic int cnt_width(input int nbits);
        return $clog2(nbits + 1);
    endfunction

endpackage

// File: rtl/shift_in_reg.sv
// rtl/shift_in_reg.sv - right-shifting serial-in register, LSB-first reassembly
module shift_in_reg #(
    parameter int NBITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             din,
    output logic [NBITS-1:0] q,
    output logic [NBITS-1:0] shifted
);

    logic [NBITS-1:0] base;
    logic [NBITS-1:0] din_msb;

    // clr with en drops any stale bits but still takes din as the new first bit.
    always_comb begin
        din_msb            = '0;
        din_msb[NBITS-1]   = din;
        base               = clr ? '0 : q;
        shifted            = (base >> 1) | din_msb;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= shifted;
        end else if (clr) begin
            q <= '0;
        end
    end

endmodule

// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - serial-to-parallel receiver with valid/ready output and overrun flag
module serial_deserializer
    import serial_pkg::*;
#(
    parameter int NBITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             bit_en,
    input  logic             Din_serie,
    input  logic             Dout_ready,
    input  logic             clr_ovr,
    output logic [NBITS-1:0] Dout,
    output logic             Dout_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = cnt_width(NBITS);

    rx_state_t        state;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic             accept;
    logic             restart;
    logic             complete;
    logic [NBITS-1:0] shreg;
    logic [NBITS-1:0] word;

    assign accept   = bit_en && (start || (state == RECV));
    assign restart  = bit_en && start;
    assign cnt_next = restart ? CW'(1) : cnt + CW'(1);
    assign complete = accept && (cnt_next == CW'(NBITS));
    assign busy     = (state == RECV);

    shift_in_reg #(
        .NBITS(NBITS)
    ) u_shift (
        .clk     (clk),
        .reset   (reset),
        .en      (accept),
        .clr     (restart),
        .din     (Din_serie),
        .q       (shreg),
        .shifted (word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (complete) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (accept) begin
            state <= RECV;
            cnt   <= cnt_next;
        end
    end

    // A completing word may replace the held one only if it is consumed this same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Dout       <= '0;
            Dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (complete && !(Dout_valid && !Dout_ready)) begin
                Dout       <= word;
                Dout_valid <= 1'b1;
            end else if (Dout_ready) begin
                Dout_valid <= 1'b0;
            end

            if (complete && Dout_valid && !Dout_ready) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
